imem_uart_loader: RTL and testbench
===================================

// Module: imem_uart_loader
// PURPOSE
//  Boot loader sitting upstream of the single-cycle CPU top: receives a program over UART,
//  writes it word-by-word into instruction memory, holds the CPU in reset meanwhile.
//  Releases the CPU (cpu_reset=0) only after a complete, error-free load; on error the CPU stays held.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency (Hz)
//  BAUD        115200       UART bit rate; BAUD_DIV = CLK_HZ/BAUD (integer divide)
//  ADDR_W      11           IMEM word-address width (matches pc[12:2])
//  TIMEOUT_CYC 10_000_000   max idle cycles between bytes once a load has started
// PORTS
//  clk_in       in   1       system clock, all logic on rising edge
//  reset        in   1       synchronous, active-high
//  uart_rx      in   1       asynchronous serial input, idle high
//  im_we        out  1       IMEM write strobe, one-cycle pulse per word
//  im_addr      out  ADDR_W  IMEM word address
//  im_wdata     out  32      IMEM write data
//  cpu_reset    out  1       held high until load completes; drives the CPU top's reset
//  load_done    out  1       sticky: program loaded, CPU released
//  load_err     out  1       sticky: framing/timeout/size/checksum error
//  words_loaded out  ADDR_W+1 count of words written so far
// BEHAVIOUR
//  Reset values: im_we=0, im_addr=0, im_wdata=0, cpu_reset=1, load_done=0, load_err=0, words_loaded=0.
//  Reset mid-load: return to S_HDR0, counters cleared, cpu_reset=1; IMEM contents untouched.
//  RX: 2-FF synchroniser on uart_rx; falling edge in idle starts a frame; start bit re-checked at
//   BAUD_DIV/2 (high -> glitch, discard); 8 data bits sampled every BAUD_DIV, LSB first; stop bit
//   sampled; stop=0 -> framing error. Byte-valid pulse is one cycle, at the stop-bit sample.
//  Protocol (little-endian): 2-byte word count N, then N*4 data bytes, [checksum byte].
//  FSM: S_HDR0 -(byte)-> S_HDR1 -(byte)-> S_DATA | S_DONE | S_ERR; S_DATA -> S_CSUM/S_DONE/S_ERR.
//   S_HDR1: N=0 -> S_DONE; N > 2**ADDR_W -> S_ERR; else S_DATA.
//   S_DATA: bytes shift into word reg byte0 first; on 4th byte, next cycle im_we=1,
//    im_addr=words_loaded[ADDR_W-1:0], im_wdata=assembled word; words_loaded increments same edge.
//    After word N-1 written -> S_CSUM (macro on) or S_DONE.
//   S_DONE: cpu_reset=0, load_done=1; further UART bytes ignored until reset.
//   S_ERR: load_err=1, cpu_reset=1, im_we never asserted; exit only by reset.
//  Timeout: outside S_HDR0 (i.e. after first byte), idle counter cleared on each byte-valid;
//   reaching TIMEOUT_CYC -> S_ERR. No timeout while waiting for first header byte.
//  Framing error in any receiving state -> S_ERR. Byte arriving during im_we cycle is captured
//   normally (write takes one cycle; byte spacing >= 10*BAUD_DIV, no overlap possible).
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: after last data byte expect one byte equal to XOR of all
//   data bytes (header excluded); match -> S_DONE, mismatch -> S_ERR (words already written stay).
//  Undefined: no checksum byte; S_DONE immediately after last im_we; S_CSUM absent.
// STRUCTURE
//  Package loader_pkg: state enum (S_HDR0,S_HDR1,S_DATA,S_CSUM,S_DONE,S_ERR), BAUD_DIV
//   calculation function, header length constant (2), bytes-per-word constant (4).
//  Sub-module uart_rx_byte (synchroniser, baud counter, bit FSM; outputs rx_byte, rx_valid,
//   rx_frame_err). Top holds protocol FSM, word assembly, counters, timeout.
// TESTING (bench uses BAUD_DIV=8, TIMEOUT_CYC=2000, ADDR_W=4)
//  Send N=2, words 0x3C011001, 0x00000000 -> im_we twice, addr 0/1, data exact; load_done=1,
//   cpu_reset falls the cycle after the final write (macro off) / after checksum 0x2C (macro on).
//  Send N=0 -> no im_we, load_done=1 after second header byte.
//  Send N=17 (>16) -> load_err=1, cpu_reset=1, no im_we.
//  Send header then stall 2000 cycles after 3rd data byte -> load_err=1, words_loaded=0.
//  Frame with stop bit=0 during S_DATA -> load_err=1; 2-cycle low glitch on idle line -> ignored.
//  Macro on, wrong checksum 0x00 -> load_err=1; assert reset mid-load -> state S_HDR0, cpu_reset=1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
package loader_pkg;

    // Protocol FSM states
    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    // UART receiver bit-level states
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

    // Clock cycles per UART bit (integer divide)
    function automatic int unsigned calc_baud_div(input int unsigned clk_hz,
                                                  input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling, glitch-rejecting start check.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int unsigned CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned HALF  = BAUD_DIV / 2;

    rx_state_t        state_q;
    rx_state_t        state_n;
    logic [1:0]       sync_q;
    logic             rx_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;

    logic rx_s;
    logic fall_c;
    logic half_hit_c;
    logic full_hit_c;
    logic sample_c;
    logic valid_n;
    logic err_n;

    assign rx_s       = sync_q[1];
    assign fall_c     = rx_prev_q & ~rx_s;
    assign half_hit_c = (cnt_q == CNT_W'(HALF - 1));
    assign full_hit_c = (cnt_q == CNT_W'(BAUD_DIV - 1));

    // Synchroniser and edge-detect history; idle level is high
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], uart_rx};
            rx_prev_q <= rx_s;
        end
    end

    // Bit FSM state register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Bit FSM next state: start bit re-checked at half period, then full-period samples
    always_comb begin
        state_n = state_q;
        case (state_q)
            RX_IDLE:  if (fall_c) state_n = RX_START;
            RX_START: if (half_hit_c) state_n = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_hit_c && (bit_q == 3'd7)) state_n = RX_STOP;
            RX_STOP:  if (full_hit_c) state_n = RX_IDLE;
            default:  state_n = RX_IDLE;
        endcase
    end

    // Bit FSM decode of sampling and completion events
    always_comb begin
        sample_c = 1'b0;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        case (state_q)
            RX_DATA: sample_c = full_hit_c;
            RX_STOP: begin
                valid_n = full_hit_c & rx_s;
                err_n   = full_hit_c & ~rx_s;
            end
            default: ;
        endcase
    end

    // Baud counter, bit index and LSB-first shift register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            if ((state_q == RX_IDLE) || (state_n != state_q) || full_hit_c) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state_q == RX_START) begin
                bit_q <= '0;
            end else if (sample_c) begin
                bit_q <= bit_q + 3'd1;
            end
            if (sample_c) begin
                shift_q <= {rx_s, shift_q[7:1]};
            end
        end
    end

    // Registered byte outputs, one-cycle strobes
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= valid_n;
            rx_frame_err <= err_n;
            if (valid_n) begin
                rx_byte <= shift_q;
            end
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// UART boot loader: fills IMEM from a length-prefixed byte stream, then releases the CPU.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_uart_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned TIMEOUT_CYC = 10_000_000
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned BAUD_DIV  = calc_baud_div(CLK_HZ, BAUD);
    localparam int unsigned TO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

    state_t          state_q;
    state_t          state_n;
    logic [7:0]      rx_byte;
    logic            rx_valid;
    logic            rx_frame_err;
    logic [15:0]     count_q;
    logic [1:0]      byte_idx_q;
    logic [31:0]     word_q;
    logic [TO_W-1:0] idle_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      csum_q;
`endif

    logic [15:0] hdr_n_c;
    logic        word_done_c;
    logic        last_written_c;
    logic        timeout_c;
    logic        timed_state_c;
    logic        im_we_n;
    logic        cpu_reset_n;
    logic        load_done_n;
    logic        load_err_n;

    uart_rx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk_in       (clk_in),
        .reset        (reset),
        .uart_rx      (uart_rx),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    assign hdr_n_c        = {rx_byte, count_q[7:0]};
    assign word_done_c    = (state_q == S_DATA) && rx_valid
                            && (byte_idx_q == 2'(BYTES_PER_WORD - 1));
    assign last_written_c = im_we && (32'(words_loaded) == 32'(count_q));
    assign timed_state_c  = (state_q == S_HDR1) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign timeout_c      = timed_state_c && !rx_valid && (idle_q == TO_W'(TIMEOUT_CYC - 1));

    // Protocol FSM state register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= S_HDR0;
        end else begin
            state_q <= state_n;
        end
    end

    // Protocol FSM next state
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_HDR0: begin
                if (rx_frame_err) begin
                    state_n = S_ERR;
                end else if (rx_valid) begin
                    state_n = S_HDR1;
                end
            end
            S_HDR1: begin
                if (rx_frame_err || timeout_c) begin
                    state_n = S_ERR;
                end else if (rx_valid) begin
                    if (hdr_n_c == 16'd0) begin
                        state_n = S_DONE;
                    end else if (32'(hdr_n_c) > MAX_WORDS) begin
                        state_n = S_ERR;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_frame_err || timeout_c) begin
                    state_n = S_ERR;
                end else if (last_written_c) begin
`ifdef LOADER_CHECKSUM_EN
                    state_n = S_CSUM;
`else
                    state_n = S_DONE;
`endif
                end
            end
            S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (rx_frame_err || timeout_c) begin
                    state_n = S_ERR;
                end else if (rx_valid) begin
                    state_n = (rx_byte == csum_q) ? S_DONE : S_ERR;
                end
`else
                state_n = S_ERR;
`endif
            end
            S_DONE:  state_n = S_DONE;
            S_ERR:   state_n = S_ERR;
            default: state_n = S_ERR;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state
    always_comb begin
        im_we_n     = 1'b0;
        cpu_reset_n = 1'b1;
        load_done_n = 1'b0;
        load_err_n  = 1'b0;
        if (word_done_c && (state_n == S_DATA)) begin
            im_we_n = 1'b1;
        end
        if (state_n == S_DONE) begin
            cpu_reset_n = 1'b0;
            load_done_n = 1'b1;
        end
        if (state_n == S_ERR) begin
            load_err_n = 1'b1;
        end
    end

    // Header length capture, word assembly, checksum and inter-byte idle counter
    always_ff @(posedge clk_in) begin
        if (reset) begin
            count_q    <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            idle_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            if ((state_q == S_HDR0) && rx_valid) begin
                count_q <= {8'h00, rx_byte};
            end else if ((state_q == S_HDR1) && rx_valid) begin
                count_q <= hdr_n_c;
            end
            if ((state_q == S_DATA) && rx_valid) begin
                byte_idx_q <= byte_idx_q + 2'd1;
                word_q     <= {rx_byte, word_q[31:8]};
`ifdef LOADER_CHECKSUM_EN
                csum_q     <= csum_q ^ rx_byte;
`endif
            end
            if (!timed_state_c || rx_valid) begin
                idle_q <= '0;
            end else if (idle_q != TO_W'(TIMEOUT_CYC - 1)) begin
                idle_q <= idle_q + TO_W'(1);
            end
        end
    end

    // Registered outputs; word count advances on the edge that launches the write
    always_ff @(posedge clk_in) begin
        if (reset) begin
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_wdata     <= '0;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            im_we     <= im_we_n;
            cpu_reset <= cpu_reset_n;
            load_done <= load_done_n;
            load_err  <= load_err_n;
            if (im_we_n) begin
                im_addr      <= words_loaded[ADDR_W-1:0];
                im_wdata     <= {rx_byte, word_q[31:8]};
                words_loaded <= words_loaded + (ADDR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader (BAUD_DIV=8, ADDR_W=4, TIMEOUT_CYC=2000).
module tb_imem_uart_loader;

    localparam int unsigned BAUD_DIV    = 8;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned TIMEOUT_CYC = 2000;

    logic              clk_in = 1'b0;
    logic              reset  = 1'b1;
    logic              uart_rx = 1'b1;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // im_we monitor state
    int          we_cnt;
    int          run_err;
    int          last_we_cyc;
    int          fall_cyc;
    logic [31:0] we_addr [4];
    logic [31:0] we_data [4];
    logic        prev_we;
    logic        prev_cpu_rst;

    imem_uart_loader #(
        .CLK_HZ      (921_600),
        .BAUD        (115_200),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .uart_rx      (uart_rx),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Record every write strobe and the cpu_reset release, sampled mid-cycle
    always @(negedge clk_in) begin
        if (reset) begin
            we_cnt      = 0;
            run_err     = 0;
            last_we_cyc = -1;
            fall_cyc    = -1;
        end else begin
            if (im_we) begin
                if (we_cnt < 4) begin
                    we_addr[we_cnt[1:0]] = 32'(im_addr);
                    we_data[we_cnt[1:0]] = im_wdata;
                end
                we_cnt      = we_cnt + 1;
                last_we_cyc = cyc;
                if (prev_we) run_err = run_err + 1;
            end
            if (prev_cpu_rst && !cpu_reset) fall_cyc = cyc;
        end
        prev_we      = im_we;
        prev_cpu_rst = cpu_reset;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset = 1'b1;
        uart_rx = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);
    endtask

    task automatic send_bit(input logic v);
        @(negedge clk_in);
        uart_rx = v;
        idle(BAUD_DIV - 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
        @(negedge clk_in);
        uart_rx = 1'b1;
        idle(4);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = w >> (8 * i);
            send_byte(t[7:0], 1'b1);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_we",     32'(im_we), 0);
        check("rst_addr",   32'(im_addr), 0);
        check("rst_wdata",  im_wdata, 0);
        check("rst_cpurst", 32'(cpu_reset), 1);
        check("rst_done",   32'(load_done), 0);
        check("rst_err",    32'(load_err), 0);
        check("rst_words",  32'(words_loaded), 0);

        // No timeout while waiting for the first header byte
        idle(2500);
        check("hdr0_no_timeout", 32'(load_err), 0);

        // Two-cycle low glitch on the idle line must not start a frame
        @(negedge clk_in);
        uart_rx = 1'b0;
        idle(2);
        uart_rx = 1'b1;
        idle(100);
        check("glitch_err",   32'(load_err), 0);
        check("glitch_words", 32'(words_loaded), 0);

        // N=2 normal load
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'h3C01_1001);
        send_word(32'h0000_0000);
`ifdef LOADER_CHECKSUM_EN
        check("n2_held_before_csum", 32'(cpu_reset), 1);
        send_byte(8'h2C, 1'b1);
`endif
        idle(4);
        check("n2_we_cnt",  32'(we_cnt), 2);
        check("n2_addr0",   we_addr[0], 0);
        check("n2_data0",   we_data[0], 32'h3C01_1001);
        check("n2_addr1",   we_addr[1], 1);
        check("n2_data1",   we_data[1], 32'h0000_0000);
        check("n2_pulse",   32'(run_err), 0);
        check("n2_done",    32'(load_done), 1);
        check("n2_cpurst",  32'(cpu_reset), 0);
        check("n2_err",     32'(load_err), 0);
        check("n2_words",   32'(words_loaded), 2);
`ifdef LOADER_CHECKSUM_EN
        check("n2_fall_after_we", 32'(fall_cyc > last_we_cyc), 1);
`else
        check("n2_fall_cycle", 32'(fall_cyc), 32'(last_we_cyc + 1));
`endif
        // Bytes after completion are ignored
        send_byte(8'h55, 1'b1);
        send_word(32'hAABB_CCDD);
        check("done_ignore_we",    32'(we_cnt), 2);
        check("done_ignore_words", 32'(words_loaded), 2);
        check("done_sticky",       32'(load_done), 1);

        // N=0: immediate completion
        do_reset();
        send_byte(8'h00, 1'b1);
        check("n0_held_after_hdr0", 32'(cpu_reset), 1);
        send_byte(8'h00, 1'b1);
        check("n0_done",   32'(load_done), 1);
        check("n0_cpurst", 32'(cpu_reset), 0);
        check("n0_we_cnt", 32'(we_cnt), 0);

        // N=16 is the largest legal count; N=17 overflows a 16-word IMEM
        do_reset();
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1);
        check("n16_no_err", 32'(load_err), 0);
        do_reset();
        send_byte(8'h11, 1'b1);
        send_byte(8'h00, 1'b1);
        check("n17_err",    32'(load_err), 1);
        check("n17_cpurst", 32'(cpu_reset), 1);
        check("n17_done",   32'(load_done), 0);
        check("n17_we_cnt", 32'(we_cnt), 0);

        // Stall after the third data byte
        do_reset();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        idle(1500);
        check("to_not_yet", 32'(load_err), 0);
        idle(600);
        check("to_err",    32'(load_err), 1);
        check("to_words",  32'(words_loaded), 0);
        check("to_we_cnt", 32'(we_cnt), 0);
        check("to_cpurst", 32'(cpu_reset), 1);

        // Framing error during data
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hA5, 1'b0);
        check("frm_err",    32'(load_err), 1);
        check("frm_we_cnt", 32'(we_cnt), 0);
        send_word(32'h0102_0304);
        check("frm_sticky_we", 32'(we_cnt), 0);
        check("frm_sticky",    32'(load_err), 1);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum: words stay written, CPU stays held
        do_reset();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'h3C01_1001);
        send_word(32'h0000_0000);
        send_byte(8'h00, 1'b1);
        check("csum_err",    32'(load_err), 1);
        check("csum_done",   32'(load_done), 0);
        check("csum_cpurst", 32'(cpu_reset), 1);
        check("csum_we_cnt", 32'(we_cnt), 2);
`endif

        // Reset mid-load restarts from the header
        do_reset();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h77, 1'b1);
        send_byte(8'h66, 1'b1);
        do_reset();
        check("mid_cpurst", 32'(cpu_reset), 1);
        check("mid_words",  32'(words_loaded), 0);
        check("mid_err",    32'(load_err), 0);
        check("mid_done",   32'(load_done), 0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'hDEAD_BEEF);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h22, 1'b1);
`endif
        idle(4);
        check("mid_reload_we",    32'(we_cnt), 1);
        check("mid_reload_addr",  we_addr[0], 0);
        check("mid_reload_data",  we_data[0], 32'hDEAD_BEEF);
        check("mid_reload_done",  32'(load_done), 1);
        check("mid_reload_words", 32'(words_loaded), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
